// File: rtl/n_div_prog.sv
// Programmable integer clock divider with glitch-free ratio changes.
// A new ratio is taken only at a period boundary; every output comes straight from a register.
module n_div_prog #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEFAULT_N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] n_in,
  input  logic             n_load,
  output logic             clk_d,
  output logic             tick,
  output logic             n_ack,
  output logic             n_err,
  output logic [WIDTH-1:0] n_active
);

  localparam logic [WIDTH-1:0] NReset = WIDTH'(DEFAULT_N);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_act_q, n_act_d;
  logic [WIDTH-1:0] pend_n_q, pend_n_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_d_q, clk_d_d;
  logic             tick_q, tick_d;
  logic             n_ack_q, n_ack_d;
  logic             n_err_q, n_err_d;

  logic [WIDTH:0]   hi;
  logic [WIDTH:0]   cnt_inc;
  logic             boundary;
  logic             load_ok;
  logic             load_bad;

  // Both values are one bit wider than the ratio, so neither can overflow at the maximum ratio.
  assign hi       = ({1'b0, n_act_q} + 1'b1) >> 1;
  assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
  assign boundary = en && (cnt_q == (n_act_q - 1'b1));
  assign load_ok  = n_load && (n_in >= WIDTH'(2));
  assign load_bad = n_load && (n_in < WIDTH'(2));

  always_comb begin
    cnt_d        = cnt_q;
    n_act_d      = n_act_q;
    pend_n_d     = pend_n_q;
    pend_valid_d = pend_valid_q;
    clk_d_d      = clk_d_q;
    tick_d       = 1'b0;
    n_ack_d      = 1'b0;
    n_err_d      = load_bad;

    if (en) begin
      if (boundary) begin
        cnt_d   = '0;
        clk_d_d = 1'b1;
        tick_d  = 1'b1;
        if (pend_valid_q) begin
          n_act_d      = pend_n_q;
          pend_valid_d = 1'b0;
          n_ack_d      = 1'b1;
        end
      end else begin
        cnt_d   = cnt_inc[WIDTH-1:0];
        clk_d_d = (cnt_inc < hi);
      end
    end

    // A load in the boundary cycle wins over the clear, so it waits for the next boundary.
    if (load_ok) begin
      pend_n_d     = n_in;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= NReset - 1'b1;
      n_act_q      <= NReset;
      pend_n_q     <= NReset;
      pend_valid_q <= 1'b0;
      clk_d_q      <= 1'b0;
      tick_q       <= 1'b0;
      n_ack_q      <= 1'b0;
      n_err_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      n_act_q      <= n_act_d;
      pend_n_q     <= pend_n_d;
      pend_valid_q <= pend_valid_d;
      clk_d_q      <= clk_d_d;
      tick_q       <= tick_d;
      n_ack_q      <= n_ack_d;
      n_err_q      <= n_err_d;
    end
  end

  assign clk_d    = clk_d_q;
  assign tick     = tick_q;
  assign n_ack    = n_ack_q;
  assign n_err    = n_err_q;
  assign n_active = n_act_q;

endmodule

// File: tb/tb_n_div_prog.sv
// Directed and random checks of n_div_prog against a period-position reference model.
module tb_n_div_prog;

  localparam int W  = 8;
  localparam int DN = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] n_in = '0;
  logic         n_load = 1'b0;
  logic         clk_d;
  logic         tick;
  logic         n_ack;
  logic         n_err;
  logic [W-1:0] n_active;

  int total = 0;
  int bad   = 0;

  // Model: position inside the current period, active ratio, queue of accepted loads.
  int m_pos = DN - 1;
  int m_n   = DN;
  int pend[$];
  bit m_clk, m_tick, m_ack, m_err;

  n_div_prog #(.WIDTH(W), .DEFAULT_N(DN)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .n_in     (n_in),
    .n_load   (n_load),
    .clk_d    (clk_d),
    .tick     (tick),
    .n_ack    (n_ack),
    .n_err    (n_err),
    .n_active (n_active)
  );

  always #5 clk = ~clk;

  task automatic mstep();
    if (rst) begin
      m_pos = DN - 1;
      m_n   = DN;
      pend.delete();
      m_clk = 0; m_tick = 0; m_ack = 0; m_err = 0;
    end else begin
      m_err  = n_load && (int'(n_in) < 2);
      m_tick = 0;
      m_ack  = 0;
      if (en) begin
        if (m_pos == m_n - 1) begin
          m_pos  = 0;
          m_tick = 1;
          m_clk  = 1;
          if (pend.size() > 0) begin
            m_n = pend[$];
            pend.delete();
            m_ack = 1;
          end
        end else begin
          m_pos = m_pos + 1;
          m_clk = (m_pos < (m_n + 1) / 2);
        end
      end
      if (n_load && int'(n_in) >= 2) pend.push_back(int'(n_in));
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("clk_d", W'(clk_d), W'(m_clk));
    chk("tick", W'(tick), W'(m_tick));
    chk("n_ack", W'(n_ack), W'(m_ack));
    chk("n_err", W'(n_err), W'(m_err));
    chk("n_active", n_active, W'(m_n));
  endtask

  task automatic step(input bit r, input bit e, input bit ld, input logic [W-1:0] ni);
    rst = r; en = e; n_load = ld; n_in = ni;
    @(posedge clk);
    mstep();
    #1;
    check_all();
    n_load = 1'b0;
    rst = 1'b0;
  endtask

  // Runs enabled idle cycles until the next enabled cycle will be a boundary.
  task automatic to_boundary();
    int guard = 0;
    while (m_pos != m_n - 1 && guard < 300) begin
      step(0, 1, 0, '0);
      guard++;
    end
    if (guard >= 300) chk("to_boundary_timeout", W'(1), W'(0));
  endtask

  initial begin
    int acks;
    int highs;
    int guard;

    // Reset, then free-running at the default ratio.
    step(1, 0, 0, '0);
    chk("reset_n_active", n_active, W'(DN));
    step(0, 1, 0, '0);
    chk("first_tick", W'(tick), W'(1));
    highs = 0;
    for (int i = 0; i < DN; i++) begin
      step(0, 1, 0, '0);
      if (i < DN - 1 && clk_d === 1'b1) highs++;
    end
    chk("default_high_cycles", W'(highs + 1), W'(4));

    // Load 5 mid-period at cnt=2.
    to_boundary();
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    step(0, 1, 1, W'(5));
    guard = 0;
    while (m_ack == 0 && guard < 20) begin
      step(0, 1, 0, '0);
      guard++;
    end
    chk("ack_5_seen", W'(n_ack), W'(1));
    chk("n_active_5", n_active, W'(5));
    highs = 1;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, '0);
      if (clk_d === 1'b1) highs++;
    end
    chk("ratio5_high_cycles", W'(highs), W'(3));

    // Illegal loads.
    step(0, 1, 1, W'(1));
    step(0, 1, 0, '0);
    step(0, 1, 1, W'(0));
    for (int i = 0; i < 8; i++) step(0, 1, 0, '0);
    chk("n_active_after_bad", n_active, W'(5));

    // Two loads in one period, then a load coinciding with the boundary.
    to_boundary();
    step(0, 1, 0, '0);
    step(0, 1, 1, W'(3));
    step(0, 1, 1, W'(6));
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, '0);
      if (n_ack === 1'b1) acks++;
    end
    chk("single_ack", W'(acks), W'(1));
    chk("n_active_6", n_active, W'(6));
    to_boundary();
    step(0, 1, 1, W'(2));
    chk("coincident_not_yet", n_active, W'(6));
    for (int i = 0; i < 6; i++) step(0, 1, 0, '0);
    chk("coincident_adopted", n_active, W'(2));

    // Freeze mid-period.
    step(0, 1, 1, W'(7));
    for (int i = 0; i < 6; i++) step(0, 1, 0, '0);
    to_boundary();
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0);

    // Reset with a pending load at cnt=4.
    to_boundary();
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
    step(0, 1, 1, W'(3));
    step(1, 1, 1, W'(9));
    chk("rst_clears_n_active", n_active, W'(DN));
    for (int i = 0; i < 20; i++) step(0, 1, 0, '0);
    chk("pending_discarded", n_active, W'(DN));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) == 0), W'($urandom_range(0, 12)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/n_div_prog.md
N_DIV_PROG -- requirements
Module: n_div_prog

Interface
REQ-001 The block SHALL have one parameter WIDTH, default 8, meaning bit width of the divide ratio and the period counter.
REQ-002 The block SHALL have one parameter DEFAULT_N, default 8, meaning the divide ratio in force after reset; legal range 2..2^WIDTH-1.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  count enable; 0 freezes the divider.
REQ-006 The block SHALL have port n_in  input  WIDTH  requested divide ratio, sampled only when n_load=1.
REQ-007 The block SHALL have port n_load  input  1  single-cycle request to adopt n_in.
REQ-008 The block SHALL have port clk_d  output  1  registered divided clock.
REQ-009 The block SHALL have port tick  output  1  one-cycle pulse, asserted in the same cycle clk_d rises.
REQ-010 The block SHALL have port n_ack  output  1  one-cycle pulse, asserted in the cycle a pending ratio becomes active.
REQ-011 The block SHALL have port n_err  output  1  one-cycle pulse, asserted in the cycle after an illegal load is rejected.
REQ-012 The block SHALL have port n_active  output  WIDTH  divide ratio currently in force.

Function
REQ-013 The block SHALL keep internal state cnt (WIDTH bits), n_act, pend_n and pend_valid; n_active SHALL equal n_act.
REQ-014 The block SHALL define hi = (n_act+1)>>1, computed at WIDTH+1 bits so it cannot overflow at n_act = 2^WIDTH-1.
REQ-015 With en=1 and cnt = n_act-1, the block SHALL set cnt to 0, clk_d to 1 and tick to 1 for one cycle; this is the period boundary.
REQ-016 With en=1 and cnt != n_act-1, the block SHALL increment cnt by 1, drive clk_d to (cnt+1 < hi) and drive tick to 0.
REQ-017 The resulting waveform SHALL have period n_act cycles, with clk_d high for ceil(n_act/2) cycles and low for floor(n_act/2) cycles.
REQ-018 With en=0, the block SHALL hold cnt and clk_d, and SHALL drive tick and n_ack to 0.
REQ-019 Loads SHALL still be accepted while en=0; adoption SHALL wait for the next enabled boundary.
REQ-020 When n_load=1 and n_in >= 2, the block SHALL write n_in to pend_n and set pend_valid, overwriting any earlier pending value (last load wins).
REQ-021 When n_load=1 and n_in < 2, the block SHALL leave pend_n and pend_valid unchanged and SHALL assert n_err in the next cycle.
REQ-022 At a boundary with pend_valid=1 (value registered before that cycle), the block SHALL set n_act to pend_n, clear pend_valid and assert n_ack in the same cycle as tick.
REQ-023 The ratio SHALL never change mid-period, so clk_d is glitch-free and every period is complete.
REQ-024 If a legal load coincides with a boundary, the block SHALL adopt the previously pending value, if any.
REQ-025 In that coincident case, the new value SHALL remain pending and SHALL be adopted at the following boundary.
REQ-026 If a legal load coincides with a boundary and nothing was pending, adoption SHALL occur at the next boundary.
REQ-027 Reloading the value already in n_act SHALL still produce n_ack at the boundary.
REQ-028 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-029 When rst=1 at a clk edge, the block SHALL set cnt=DEFAULT_N-1, n_act=DEFAULT_N, pend_valid=0 and pend_n=DEFAULT_N.
REQ-030 The same reset SHALL drive clk_d=0, tick=0, n_ack=0 and n_err=0.
REQ-031 rst SHALL take priority over en and n_load, and a pending ratio SHALL be discarded by reset mid-operation.
REQ-032 The first enabled cycle after reset SHALL be a boundary (clk_d rises, tick=1).

Verification
REQ-033 The bench SHALL cover: rst then en=1, DEFAULT_N=8 -> tick in first enabled cycle and every 8 cycles thereafter; clk_d high 4 cycles, low 4 cycles; n_active=8.
REQ-034 The bench SHALL cover: n_load with n_in=5 at cnt=2 -> no change until the boundary; then n_ack=1 with tick, n_active=5, clk_d high 3, low 2.
REQ-035 The bench SHALL cover: n_load with n_in=1, and separately n_in=0 -> n_err pulses one cycle later; n_active and the waveform unchanged; no n_ack.
REQ-036 The bench SHALL cover: loads of 3 then 6 in one period -> single n_ack; n_active=6; then coincident-boundary load of 2 -> 2 adopted one period later.
REQ-037 The bench SHALL cover: en=0 for 5 cycles mid-period -> cnt, clk_d and n_active frozen; no tick; period completes normally after en returns to 1.
REQ-038 The bench SHALL cover: rst pulsed with a load pending at cnt=4 -> next cycle holds reset values and n_active=DEFAULT_N; pending value never adopted.
